// File: rtl/hazard_control_unit.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: RAW detection,
// forwarding selects, counted load/RAW stalls, MEM-stage redirect flushes and event counters.
module hazard_control_unit #(
  parameter bit FORWARDING_EN = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_write_reg_i,
  input  logic [4:0]       ex_rs_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             mem_reg_write_i,
  input  logic [4:0]       mem_write_reg_i,
  input  logic             wb_reg_write_i,
  input  logic [4:0]       wb_write_reg_i,
  input  logic             mem_redirect_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             id_bypass_a_o,
  output logic             id_bypass_b_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] redirect_count_o
);

  typedef enum logic {RUN, STALL} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stallCount_q, redirectCount_q;

  logic       exHit, memHit, stallCycle;
  logic [1:0] need;
  logic [1:0] fwdA, fwdB;

  // $0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic regMatch(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst == src) && (dst != 5'd0);
  endfunction

  function automatic logic [1:0] fwdSel(input logic [4:0] src);
    if (regMatch(mem_reg_write_i, mem_write_reg_i, src))
      return 2'b10;
    else if (regMatch(wb_reg_write_i, wb_write_reg_i, src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    exHit  = (id_use_rs_i && regMatch(ex_reg_write_i, ex_write_reg_i, id_rs_i)) ||
             (id_use_rt_i && regMatch(ex_reg_write_i, ex_write_reg_i, id_rt_i));
    memHit = (id_use_rs_i && regMatch(mem_reg_write_i, mem_write_reg_i, id_rs_i)) ||
             (id_use_rt_i && regMatch(mem_reg_write_i, mem_write_reg_i, id_rt_i));
    fwdA   = fwdSel(ex_rs_i);
    fwdB   = fwdSel(ex_rt_i);
    need   = 2'd0;
    if (FORWARDING_EN) begin
      if (ex_mem_read_i && exHit) need = 2'd1;
    end else begin
      if (exHit)       need = 2'd2;
      else if (memHit) need = 2'd1;
    end
  end

  assign stallCycle = !mem_redirect_i && ((state_q == STALL) || (need != 2'd0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Detection is only sampled in RUN; STALL just drains the loaded count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mem_redirect_i) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (need != 2'd0) begin
            cnt_d   = need - 2'd1;
            state_d = (cnt_d != 2'd0) ? STALL : RUN;
          end
        end
        STALL: begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_d == 2'd0) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    fwd_a_o        = 2'b00;
    fwd_b_o        = 2'b00;
    id_bypass_a_o  = 1'b0;
    id_bypass_b_o  = 1'b0;
    if (rst_ni) begin
      if (mem_redirect_i) begin
        if_id_flush_o  = 1'b1;
        id_ex_flush_o  = 1'b1;
        ex_mem_flush_o = 1'b1;
      end else if (stallCycle) begin
        pc_write_o    = 1'b0;
        if_id_write_o = 1'b0;
        id_ex_flush_o = 1'b1;
      end
      if (FORWARDING_EN) begin
        fwd_a_o = fwdA;
        fwd_b_o = fwdB;
      end
      id_bypass_a_o = regMatch(wb_reg_write_i, wb_write_reg_i, id_rs_i);
      id_bypass_b_o = regMatch(wb_reg_write_i, wb_write_reg_i, id_rt_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stallCount_q    <= '0;
      redirectCount_q <= '0;
    end else begin
      if (stallCycle && (stallCount_q != CNT_MAX))
        stallCount_q <= stallCount_q + 1'b1;
      if (mem_redirect_i && (redirectCount_q != CNT_MAX))
        redirectCount_q <= redirectCount_q + 1'b1;
    end
  end

  assign stall_count_o    = stallCount_q;
  assign redirect_count_o = redirectCount_q;

endmodule
